datapath_param: RTL and testbench
=================================

# datapath_param

Parametrised multicycle processor datapath: program counter, instruction register, register file, operand latches, ALU and ALU-out register, driven cycle-by-cycle by an external multicycle controller. It generalises the fixed 8-bit datapath to any data width and register count. It adds an internal fetch sequencer that assembles an IWIDTH-bit instruction from WIDTH-bit memory beats on its own, replacing the controller-driven one-hot `irwrite` strobes. It sits between the controller and the byte-wide memory port.

## Interface
- WIDTH, 8: datapath/memory word width; ≥8.
- REGBITS, 3: register address bits; 2^REGBITS registers; ≤5.
- IWIDTH, 32: instruction width; integer multiple of WIDTH; NBEATS = IWIDTH/WIDTH.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- memdata  in  WIDTH  memory read data, combinational from `adr`.
- fetch_start  in  1  request instruction fetch; sampled in IDLE only.
- alusrca, memtoreg, regdst, iord, pcen, regwrite  in  1 each  controller strobes.
- pcsrc, alusrcb  in  2 each  mux selects.
- alucontrol  in  3  ALU op.
- adr  out  WIDTH  memory address: iord ? ALUOut : PC (forced to PC in FETCH).
- writedata  out  WIDTH  B latch (store data).
- instr  out  IWIDTH  instruction register.
- pcvalue  out  WIDTH  PC.
- zero  out  1  ALU result == 0 (combinational).
- fetch_done  out  1  one-cycle pulse, instruction complete.

## Operation
- Registers: PC, IR, MDR, A, B, ALUOut, regfile; r0 reads 0, writes to r0 discarded.
- Fields: rs = instr[21+:REGBITS], rt = instr[16+:REGBITS], rd = instr[11+:REGBITS], imm = instr[WIDTH-1:0].
- Every cycle: MDR<=memdata, A<=rf[rs], B<=rf[rt], ALUOut<=ALU result.
- ALU srcA = alusrca ? A : PC. srcB by alusrcb: 0 B, 1 constant 1, 2 imm, 3 imm<<2 (truncated to WIDTH).
- alucontrol: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (unsigned compare, result 1/0); others give 0. All arithmetic modulo 2^WIDTH, carries dropped.
- Register write (regwrite): address regdst ? rd : rt; data memtoreg ? MDR : ALUOut.
- PC load (pcen): pcsrc 0 ALU result, 1 ALUOut, 2 {instr[WIDTH-3:0],2'b00}, 3 hold.
- Sequencer states: IDLE -> FETCH (fetch_start=1) -> DONE (after beat NBEATS-1) -> IDLE.
- FETCH beat k (k=0..NBEATS-1, one per cycle): instr[k*WIDTH +: WIDTH] <= memdata at adr=PC; PC <= PC+1 (wraps). Beat 0 = least-significant slice.
- In FETCH: external pcen, regwrite and iord ignored; other IR slices hold.
- DONE: fetch_done=1 for exactly one cycle; external controls active again; fetch_start ignored in DONE and FETCH.

## Timing
- Reset (async, on reset low): PC, IR, MDR, A, B, ALUOut, all registers = 0; state IDLE; fetch_done=0; hence adr=0, writedata=0, instr=0, pcvalue=0, zero=1 (ALU AND of zeros = 0).
- Reset mid-fetch: abort immediately, partial IR discarded (cleared).
- Fetch latency: fetch_start high at edge n -> beats at edges n+1..n+NBEATS -> fetch_done high during cycle after edge n+NBEATS; earliest next fetch_start accepted at edge n+NBEATS+2.
- Register-file write at the edge; same-cycle read returns old value; A/B reflect new value one edge later.
- PC wraps from 2^WIDTH-1 to 0 during fetch and on pcen.

## Test plan
- Reset: drive reset low during FETCH beat 2 -> instr=0, pcvalue=0, fetch_done=0, state IDLE; after release fetch restarts only on new fetch_start.
- Fetch (WIDTH=8): PC=0, memdata 0x20,0x20,0x85,0x00 on beats 0..3 -> instr=0x00852020, pcvalue=4, fetch_done high one cycle only.
- R-type: load r4=0x33, r5=0x24 via memtoreg/regwrite; with instr 0x00852020, alusrca=1, alusrcb=0, alucontrol=010, then regdst=1, regwrite=1 -> r4=0x57, writedata=0x24.
- Branch compare: A=B=0x24, alucontrol=110 -> zero=1; pcsrc=1, pcen=1 loads ALUOut into PC next edge; pcen asserted during FETCH has no effect.
- Wrap: PC=0xFE, fetch 4 beats -> adr sequence 0xFE,0xFF,0x00,0x01; pcvalue=0x02.
- WIDTH=16, IWIDTH=32: memdata 0x2020,0x0085 -> instr=0x00852020 after 2 beats, pcvalue=2, fetch_done in third cycle.

Source files
------------

// File: rtl/datapath_param.sv
// Parametrised multicycle datapath: PC, IR, MDR, A/B latches, regfile, ALU/ALUOut,
// with an internal sequencer that assembles IWIDTH-bit instructions from WIDTH-bit beats.
module datapath_param #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned REGBITS = 3,
   parameter int unsigned IWIDTH  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  memdata,
   input  logic              fetch_start,
   input  logic              alusrca,
   input  logic              memtoreg,
   input  logic              regdst,
   input  logic              iord,
   input  logic              pcen,
   input  logic              regwrite,
   input  logic [1:0]        pcsrc,
   input  logic [1:0]        alusrcb,
   input  logic [2:0]        alucontrol,
   output logic [WIDTH-1:0]  adr,
   output logic [WIDTH-1:0]  writedata,
   output logic [IWIDTH-1:0] instr,
   output logic [WIDTH-1:0]  pcvalue,
   output logic              zero,
   output logic              fetch_done
);
   localparam int unsigned NBEATS = IWIDTH / WIDTH;
   localparam int unsigned NREGS  = 1 << REGBITS;
   localparam int unsigned BEATW  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

   state_t             state;
   logic [BEATW-1:0]   beat;
   logic [WIDTH-1:0]   pc, mdr, a, b, aluout;
   logic [WIDTH-1:0]   rf [NREGS];
   logic [WIDTH-1:0]   srca, srcb, alu_result, imm, wd;
   logic [REGBITS-1:0] rs, rt, rd, wa;
   logic               fetching;

   assign rs       = instr[21 +: REGBITS];
   assign rt       = instr[16 +: REGBITS];
   assign rd       = instr[11 +: REGBITS];
   assign imm      = instr[WIDTH-1:0];
   assign fetching = (state == S_FETCH);
   assign wa       = regdst ? rd : rt;
   assign wd       = memtoreg ? mdr : aluout;

   // ALU operand selection and operation; SLT is an unsigned compare
   always_comb begin
      srca = alusrca ? a : pc;
      case (alusrcb)
         2'd0:    srcb = b;
         2'd1:    srcb = WIDTH'(1);
         2'd2:    srcb = imm;
         default: srcb = {imm[WIDTH-3:0], 2'b00};
      endcase
      case (alucontrol)
         3'b000:  alu_result = srca & srcb;
         3'b001:  alu_result = srca | srcb;
         3'b010:  alu_result = srca + srcb;
         3'b110:  alu_result = srca - srcb;
         3'b111:  alu_result = WIDTH'(srca < srcb);
         default: alu_result = '0;
      endcase
   end

   assign zero      = (alu_result == '0);
   assign adr       = (!fetching && iord) ? aluout : pc;
   assign writedata = b;
   assign pcvalue   = pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         beat       <= '0;
         pc         <= '0;
         mdr        <= '0;
         a          <= '0;
         b          <= '0;
         aluout     <= '0;
         instr      <= '0;
         fetch_done <= 1'b0;
         for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
      end else begin
         mdr        <= memdata;
         a          <= rf[rs];
         b          <= rf[rt];
         aluout     <= alu_result;
         fetch_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (fetch_start) begin
                  state <= S_FETCH;
                  beat  <= '0;
               end
            end
            S_FETCH: begin
               for (int unsigned k = 0; k < NBEATS; k++)
                  if (beat == BEATW'(k)) instr[k*WIDTH +: WIDTH] <= memdata;
               if (beat == BEATW'(NBEATS - 1)) begin
                  state      <= S_DONE;
                  fetch_done <= 1'b1;
               end else begin
                  beat <= beat + BEATW'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
         // Fetch owns the PC and blocks register writes until it completes
         if (fetching) begin
            pc <= pc + WIDTH'(1);
         end else begin
            if (pcen) begin
               case (pcsrc)
                  2'd0:    pc <= alu_result;
                  2'd1:    pc <= aluout;
                  2'd2:    pc <= {instr[WIDTH-3:0], 2'b00};
                  default: pc <= pc;
               endcase
            end
            if (regwrite && (wa != '0)) rf[wa] <= wd;
         end
      end
   end
endmodule

// File: tb/tb_datapath_param.sv
// Randomised and directed bench for datapath_param against a cycle-level reference model;
// a second WIDTH=16 instance covers the two-beat fetch.
module tb_datapath_param;
   logic        clk, reset;
   logic [7:0]  memdata, adr, writedata, pcvalue;
   logic        fetch_start, alusrca, memtoreg, regdst, iord, pcen, regwrite;
   logic [1:0]  pcsrc, alusrcb;
   logic [2:0]  alucontrol;
   logic [31:0] instr;
   logic        zero, fetch_done;
   logic [7:0]  mem [256];

   logic [15:0] memdata16, adr16, writedata16, pcvalue16;
   logic [31:0] instr16;
   logic        zero16, fetch_done16, fs16;
   logic [15:0] mem16 [4];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [7:0]  m_pc, m_mdr, m_a, m_b, m_alu;
   logic [31:0] m_ir;
   logic [7:0]  m_rf [8];
   int          m_left;
   bit          m_done;

   assign memdata   = mem[adr];
   assign memdata16 = (adr16 < 16'd4) ? mem16[adr16[1:0]] : 16'h0;

   datapath_param u_dut (
      .clk(clk), .reset(reset), .memdata(memdata), .fetch_start(fetch_start),
      .alusrca(alusrca), .memtoreg(memtoreg), .regdst(regdst), .iord(iord),
      .pcen(pcen), .regwrite(regwrite), .pcsrc(pcsrc), .alusrcb(alusrcb),
      .alucontrol(alucontrol), .adr(adr), .writedata(writedata), .instr(instr),
      .pcvalue(pcvalue), .zero(zero), .fetch_done(fetch_done));

   datapath_param #(.WIDTH(16), .REGBITS(3), .IWIDTH(32)) u_dut16 (
      .clk(clk), .reset(reset), .memdata(memdata16), .fetch_start(fs16),
      .alusrca(1'b0), .memtoreg(1'b0), .regdst(1'b0), .iord(1'b0),
      .pcen(1'b0), .regwrite(1'b0), .pcsrc(2'b00), .alusrcb(2'b00),
      .alucontrol(3'b000), .adr(adr16), .writedata(writedata16), .instr(instr16),
      .pcvalue(pcvalue16), .zero(zero16), .fetch_done(fetch_done16));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] alu_ref(input logic [7:0] x, input logic [7:0] y,
                                          input logic [2:0] op);
      case (op)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return x + y;
         3'd6:    return x - y;
         3'd7:    return (x < y) ? 8'd1 : 8'd0;
         default: return 8'd0;
      endcase
   endfunction

   function automatic logic [7:0] m_result();
      logic [7:0] sa, sb;
      sa = alusrca ? m_a : m_pc;
      case (alusrcb)
         2'd0:    sb = m_b;
         2'd1:    sb = 8'd1;
         2'd2:    sb = m_ir[7:0];
         default: sb = 8'(m_ir[7:0] * 4);
      endcase
      return alu_ref(sa, sb, alucontrol);
   endfunction

   function automatic logic [7:0] m_adr();
      return (m_left > 0) ? m_pc : (iord ? m_alu : m_pc);
   endfunction

   task automatic model_reset();
      m_pc = 0; m_mdr = 0; m_a = 0; m_b = 0; m_alu = 0; m_ir = 0;
      m_left = 0; m_done = 0;
      for (int i = 0; i < 8; i++) m_rf[i] = 0;
   endtask

   // one rising edge of the reference machine, all next values from old values
   task automatic model_step();
      logic [7:0] res, md, wd, npc;
      int rs, rt, rd, wa, sh;
      bit was_fetch, was_done;
      res = m_result();
      md  = mem[m_adr()];
      rs  = int'((m_ir >> 21) & 32'd7);
      rt  = int'((m_ir >> 16) & 32'd7);
      rd  = int'((m_ir >> 11) & 32'd7);
      wa  = regdst ? rd : rt;
      wd  = memtoreg ? m_mdr : m_alu;
      was_fetch = (m_left > 0);
      was_done  = m_done;
      npc = m_pc;
      if (was_fetch) npc = m_pc + 8'd1;
      else if (pcen) begin
         case (pcsrc)
            2'd0:    npc = res;
            2'd1:    npc = m_alu;
            2'd2:    npc = 8'(m_ir * 4);
            default: npc = m_pc;
         endcase
      end
      if (was_fetch) begin
         sh   = (4 - m_left) * 8;
         m_ir = (m_ir & ~(32'hFF << sh)) | (32'(md) << sh);
      end
      m_a   = m_rf[rs];
      m_b   = m_rf[rt];
      m_mdr = md;
      m_alu = res;
      m_pc  = npc;
      if (!was_fetch && regwrite && wa != 0) m_rf[wa] = wd;
      m_done = was_fetch && (m_left == 1);
      if (was_fetch) m_left--;
      else if (!was_done && fetch_start) m_left = 4;
   endtask

   task automatic check_all();
      check("adr", 32'(adr), 32'(m_adr()));
      check("writedata", 32'(writedata), 32'(m_b));
      check("instr", instr, m_ir);
      check("pcvalue", 32'(pcvalue), 32'(m_pc));
      check("zero", 32'(zero), 32'(m_result() == 8'd0));
      check("fetch_done", 32'(fetch_done), 32'(m_done));
   endtask

   task automatic ctl(input logic fs, input logic asa, input logic mtr, input logic rdst,
                      input logic io, input logic pe, input logic rw,
                      input logic [1:0] ps, input logic [1:0] asb, input logic [2:0] ac);
      fetch_start = fs; alusrca = asa; memtoreg = mtr; regdst = rdst; iord = io;
      pcen = pe; regwrite = rw; pcsrc = ps; alusrcb = asb; alucontrol = ac;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      reset = 1'b0;
      fs16  = 1'b0;
      ctl(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0);
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[0] = 8'h20; mem[1] = 8'h20; mem[2] = 8'h85; mem[3] = 8'h00;
      mem16[0] = 16'h2020; mem16[1] = 16'h0085; mem16[2] = 16'hFFFF; mem16[3] = 16'hFFFF;
      model_reset();
      #1;
      check("rst_adr", 32'(adr), 32'h0);
      check("rst_writedata", 32'(writedata), 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_pcvalue", 32'(pcvalue), 32'h0);
      check("rst_zero", 32'(zero), 32'h1);
      check("rst_fetch_done", 32'(fetch_done), 32'h0);
      check("rst16_zero", 32'(zero16), 32'h1);
      check("rst16_adr_wd", 32'({adr16, writedata16}), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // two-beat fetch on the 16-bit instance
      fs16 = 1'b1;
      cycle();
      fs16 = 1'b0;
      cycle();
      check("f16_done_early", 32'(fetch_done16), 32'h0);
      cycle();
      check("f16_instr", instr16, 32'h00852020);
      check("f16_pcvalue", 32'(pcvalue16), 32'h2);
      check("f16_done", 32'(fetch_done16), 32'h1);
      cycle();
      check("f16_done_pulse", 32'(fetch_done16), 32'h0);

      // four-beat fetch from PC=0
      ctl(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0);
      cycle();
      ctl(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0);
      for (int i = 0; i < 4; i++) cycle();
      check("fetch_instr", instr, 32'h00852020);
      check("fetch_pc", 32'(pcvalue), 32'h4);
      check("fetch_done_hi", 32'(fetch_done), 32'h1);
      cycle();
      check("fetch_done_lo", 32'(fetch_done), 32'h0);

      // R-type: r4=0x33, r5=0x24, r4 <= r4 + r5
      mem[4] = 8'h33;
      cycle();
      mem[4] = 8'h24;
      ctl(0, 0, 1, 1, 0, 0, 1, 2'd0, 2'd0, 3'd0);
      cycle();
      ctl(0, 0, 1, 0, 0, 0, 1, 2'd0, 2'd0, 3'd0);
      cycle();
      ctl(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0);
      cycle();
      ctl(0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'b010);
      cycle();
      ctl(0, 1, 0, 1, 0, 0, 1, 2'd0, 2'd0, 3'b010);
      cycle();
      ctl(0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'b001);
      cycle();
      ctl(0, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0, 3'b001);
      cycle();
      check("rtype_r4_or_b", 32'(adr), 32'h77);
      check("rtype_writedata", 32'(writedata), 32'h24);

      // branch compare: A=B=0x24, SUB gives zero, then PC <= ALUOut
      ctl(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0);
      cycle();
      ctl(0, 0, 1, 1, 0, 0, 1, 2'd0, 2'd0, 3'd0);
      cycle();
      ctl(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0);
      cycle();
      ctl(0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'b110);
      #1;
      check("br_zero", 32'(zero), 32'h1);
      cycle();
      ctl(0, 1, 0, 0, 0, 1, 0, 2'd1, 2'd0, 3'b110);
      cycle();
      check("br_pc_load", 32'(pcvalue), 32'h0);
      ctl(1, 1, 0, 0, 0, 0, 0, 2'd1, 2'd0, 3'b001);
      cycle();
      ctl(0, 1, 0, 0, 0, 1, 1, 2'd1, 2'd0, 3'b001);
      for (int i = 0; i < 4; i++) cycle();
      check("fetch_ignores_pcen", 32'(pcvalue), 32'h4);
      ctl(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0);

      // wrap: r4=0xFD, PC <= r4+1 = 0xFE, then fetch across 0xFF->0x00
      mem[4] = 8'hFD; mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22;
      cycle();
      ctl(0, 0, 1, 1, 0, 0, 1, 2'd0, 2'd0, 3'd0);
      cycle();
      ctl(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0);
      cycle();
      ctl(0, 1, 0, 0, 0, 1, 0, 2'd0, 2'd1, 3'b010);
      cycle();
      check("wrap_pc_set", 32'(pcvalue), 32'hFE);
      ctl(1, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 3'd0);
      cycle();
      check("wrap_adr0", 32'(adr), 32'hFE);
      ctl(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 3'd0);
      cycle();
      check("wrap_adr1", 32'(adr), 32'hFF);
      cycle();
      check("wrap_adr2", 32'(adr), 32'h00);
      cycle();
      check("wrap_adr3", 32'(adr), 32'h01);
      cycle();
      check("wrap_pc_end", 32'(pcvalue), 32'h02);
      ctl(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0);
      cycle();

      // reset during beat 2 aborts the fetch
      ctl(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0);
      cycle();
      ctl(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0);
      cycle();
      cycle();
      #2 reset = 1'b0;
      model_reset();
      #1;
      check("midrst_instr", instr, 32'h0);
      check("midrst_pc", 32'(pcvalue), 32'h0);
      check("midrst_done", 32'(fetch_done), 32'h0);
      check_all();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      check("midrst_no_restart", 32'(pcvalue), 32'h0);
      ctl(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0);
      cycle();
      ctl(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0);
      for (int i = 0; i < 5; i++) cycle();

      // randomised controls and memory against the reference model
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(15) == 0) mem[$urandom_range(255)] = 8'($urandom);
         ctl($urandom_range(3) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
             3'($urandom));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
